// File: rtl/coincidence_event_logger.sv
// -----------------------------------------------------------------------------
// coincidence_event_logger
//
// Turns the level-style output of the two-channel coincidence trigger into
// timestamped event records. Each rising edge of TRIGGER_IN that arrives while
// logging is enabled, not paused for readout and outside the programmable
// hold-off window is "accepted": its timestamp is pushed into a small FIFO
// that the ESP32 readout path drains with RD_EN. Accepted and dropped
// (FIFO-full) events are counted for rate monitoring.
//
// Ports
//   CLK          system clock, all logic on the rising edge
//   RESET        asynchronous active-low reset
//   TRIGGER_IN   coincidence trigger level (may stay high for many cycles)
//   read_mode    1 = acquisition paused for readout, no new events accepted
//   mconfig      [7:0] hold-off cycles, [8] clear (level), [9] enable,
//                [15:10] reserved and ignored
//   RD_EN        pop request, one entry per asserted cycle
//   RD_DATA      popped timestamp, holds its value between pops
//   RD_VALID     one-cycle strobe qualifying RD_DATA
//   FIFO_EMPTY   FIFO holds no entries
//   FIFO_FULL    FIFO holds DEPTH entries
//   FIFO_COUNT   current FIFO occupancy
//   EVENT_COUNT  accepted events since clear/reset (wraps)
//   DROP_COUNT   accepted events lost to a full FIFO (saturates)
// -----------------------------------------------------------------------------
module coincidence_event_logger #(
    parameter int DEPTH      = 16,
    parameter int TS_WIDTH   = 32,
    parameter int DROP_WIDTH = 16
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    TRIGGER_IN,
    input  logic                    read_mode,
    input  logic [15:0]             mconfig,
    input  logic                    RD_EN,
    output logic [TS_WIDTH-1:0]     RD_DATA,
    output logic                    RD_VALID,
    output logic                    FIFO_EMPTY,
    output logic                    FIFO_FULL,
    output logic [$clog2(DEPTH):0]  FIFO_COUNT,
    output logic [TS_WIDTH-1:0]     EVENT_COUNT,
    output logic [DROP_WIDTH-1:0]   DROP_COUNT
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]      FULL_LEVEL = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0]     PTR_ONE    = ADDR_W'(1);
    localparam logic [TS_WIDTH-1:0]   TS_ONE     = TS_WIDTH'(1);
    localparam logic [DROP_WIDTH-1:0] DROP_ONE   = DROP_WIDTH'(1);
    localparam logic [DROP_WIDTH-1:0] DROP_MAX   = '1;

    // ------------------------------------------------------------------
    // Configuration fields
    // ------------------------------------------------------------------
    logic [7:0] cfg_holdoff;
    logic       cfg_clear;
    logic       cfg_enable;
    logic       unused_cfg_bits;

    assign cfg_holdoff     = mconfig[7:0];
    assign cfg_clear       = mconfig[8];
    assign cfg_enable      = mconfig[9];
    assign unused_cfg_bits = ^mconfig[15:10];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [TS_WIDTH-1:0] timestamp;
    logic                trig_d;
    logic [7:0]          holdoff;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   rd_ptr;
    logic [TS_WIDTH-1:0] mem [DEPTH];

    // ------------------------------------------------------------------
    // Event qualification
    // ------------------------------------------------------------------
    logic trig_rise;
    logic accept;
    logic fifo_full_now;
    logic do_pop;
    logic do_write;
    logic do_drop;

    assign trig_rise     = TRIGGER_IN & ~trig_d;
    assign accept        = trig_rise & cfg_enable & ~read_mode & ~cfg_clear
                         & (holdoff == 8'd0);
    assign fifo_full_now = (FIFO_COUNT == FULL_LEVEL);

    // A pop needs an entry present before this edge, so an accept into an
    // empty FIFO cannot be popped in the same cycle.
    assign do_pop   = RD_EN & ~FIFO_EMPTY & ~cfg_clear;
    // When full, a simultaneous pop frees the slot the write lands in.
    assign do_write = accept & (~fifo_full_now | do_pop);
    assign do_drop  = accept & fifo_full_now & ~do_pop;

    // ------------------------------------------------------------------
    // Next-state for occupancy and hold-off
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] count_next;
    logic [7:0]       holdoff_next;

    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        count_next = FIFO_COUNT;
        if (cfg_clear) begin
            count_next = '0;
        end else if (do_write && !do_pop) begin
            count_next = FIFO_COUNT + CNT_ONE;
        end else if (do_pop && !do_write) begin
            count_next = FIFO_COUNT - CNT_ONE;
        end
    end

    always_comb begin
        holdoff_next = holdoff;
        if (cfg_clear) begin
            holdoff_next = 8'd0;
        end else if (accept) begin
            holdoff_next = cfg_holdoff;
        end else if (holdoff != 8'd0) begin
            holdoff_next = holdoff - 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Control, counters and read port
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            timestamp   <= '0;
            trig_d      <= 1'b0;
            holdoff     <= 8'd0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            FIFO_COUNT  <= '0;
            FIFO_EMPTY  <= 1'b1;
            FIFO_FULL   <= 1'b0;
            RD_DATA     <= '0;
            RD_VALID    <= 1'b0;
            EVENT_COUNT <= '0;
            DROP_COUNT  <= '0;
        end else begin
            trig_d     <= TRIGGER_IN;
            holdoff    <= holdoff_next;
            FIFO_COUNT <= count_next;
            FIFO_EMPTY <= (count_next == '0);
            FIFO_FULL  <= (count_next == FULL_LEVEL);
            RD_VALID   <= do_pop;

            if (do_pop) begin
                RD_DATA <= mem[rd_ptr];
            end

            if (cfg_clear) begin
                timestamp   <= '0;
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                EVENT_COUNT <= '0;
                DROP_COUNT  <= '0;
            end else begin
                timestamp <= timestamp + TS_ONE;
                if (do_write) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
                if (accept) begin
                    EVENT_COUNT <= EVENT_COUNT + TS_ONE;
                end
                if (do_drop && (DROP_COUNT != DROP_MAX)) begin
                    DROP_COUNT <= DROP_COUNT + DROP_ONE;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Timestamp storage
    // ------------------------------------------------------------------
    // NOTE: the storage array is deliberately not reset; the pointers and
    // occupancy decide which entries are meaningful, so stale contents after
    // reset or clear are never observed.
    always_ff @(posedge CLK) begin
        if (do_write) begin
            mem[wr_ptr] <= timestamp;
        end
    end

endmodule

// File: tb/tb_coincidence_event_logger.sv
module tb_coincidence_event_logger;

    localparam int DEPTH      = 16;
    localparam int TS_WIDTH   = 32;
    localparam int DROP_WIDTH = 16;
    localparam int CW         = $clog2(DEPTH) + 1;

    logic                  CLK = 1'b0;
    logic                  RESET;
    logic                  TRIGGER_IN;
    logic                  read_mode;
    logic [15:0]           mconfig;
    logic                  RD_EN;
    logic [TS_WIDTH-1:0]   RD_DATA;
    logic                  RD_VALID;
    logic                  FIFO_EMPTY;
    logic                  FIFO_FULL;
    logic [CW-1:0]         FIFO_COUNT;
    logic [TS_WIDTH-1:0]   EVENT_COUNT;
    logic [DROP_WIDTH-1:0] DROP_COUNT;

    coincidence_event_logger #(
        .DEPTH      (DEPTH),
        .TS_WIDTH   (TS_WIDTH),
        .DROP_WIDTH (DROP_WIDTH)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .TRIGGER_IN  (TRIGGER_IN),
        .read_mode   (read_mode),
        .mconfig     (mconfig),
        .RD_EN       (RD_EN),
        .RD_DATA     (RD_DATA),
        .RD_VALID    (RD_VALID),
        .FIFO_EMPTY  (FIFO_EMPTY),
        .FIFO_FULL   (FIFO_FULL),
        .FIFO_COUNT  (FIFO_COUNT),
        .EVENT_COUNT (EVENT_COUNT),
        .DROP_COUNT  (DROP_COUNT)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural reference: a cycle counter, a queue of timestamps and
    // plain integer counters derived from the event rules.
    logic [31:0] m_ts;
    logic        m_trig_prev;
    int          m_hold;
    logic [31:0] m_q[$];
    logic [31:0] m_evt;
    int          m_drop;
    logic        m_valid;
    logic [31:0] m_data;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_ts        = 0;
        m_trig_prev = 1'b0;
        m_hold      = 0;
        m_q.delete();
        m_evt       = 0;
        m_drop      = 0;
        m_valid     = 1'b0;
        m_data      = 0;
    endfunction

    // Advance the reference by one clock using the inputs presented now.
    function automatic void model_step();
        logic rise;
        logic acc;
        rise = TRIGGER_IN && !m_trig_prev;
        acc  = rise && mconfig[9] && !read_mode && !mconfig[8] && (m_hold == 0);
        m_trig_prev = TRIGGER_IN;
        if (mconfig[8]) begin
            m_q.delete();
            m_evt   = 0;
            m_drop  = 0;
            m_hold  = 0;
            m_valid = 1'b0;
            m_ts    = 0;
        end else begin
            m_valid = 1'b0;
            if (RD_EN && m_q.size() > 0) begin
                m_data  = m_q.pop_front();
                m_valid = 1'b1;
            end
            if (acc) begin
                m_evt++;
                if (m_q.size() < DEPTH) m_q.push_back(m_ts);
                else if (m_drop < (1 << DROP_WIDTH) - 1) m_drop++;
                m_hold = int'(mconfig[7:0]);
            end else if (m_hold > 0) begin
                m_hold--;
            end
            m_ts++;
        end
    endfunction

    task automatic step();
        model_step();
        @(posedge CLK);
        #1;
        check("rd_valid",    64'(RD_VALID),    64'(m_valid));
        check("rd_data",     64'(RD_DATA),     64'(m_data));
        check("fifo_count",  64'(FIFO_COUNT),  64'(m_q.size()));
        check("fifo_empty",  64'(FIFO_EMPTY),  64'(m_q.size() == 0));
        check("fifo_full",   64'(FIFO_FULL),   64'(m_q.size() == DEPTH));
        check("event_count", 64'(EVENT_COUNT), 64'(m_evt));
        check("drop_count",  64'(DROP_COUNT),  64'(m_drop));
    endtask

    task automatic set_cfg(input logic [7:0] ho);
        mconfig = {6'b0, 1'b1, 1'b0, ho};
    endtask

    task automatic do_clear();
        mconfig[8] = 1'b1;
        step();
        mconfig[8] = 1'b0;
    endtask

    task automatic pulse();
        TRIGGER_IN = 1'b1;
        step();
        TRIGGER_IN = 1'b0;
        step();
    endtask

    task automatic run_until(input logic [31:0] t);
        for (int i = 0; i < 1000 && m_ts != t; i++) step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 64'(RD_VALID),    64'(0));
        check({tag, "_data"},  64'(RD_DATA),     64'(0));
        check({tag, "_empty"}, 64'(FIFO_EMPTY),  64'(1));
        check({tag, "_full"},  64'(FIFO_FULL),   64'(0));
        check({tag, "_count"}, 64'(FIFO_COUNT),  64'(0));
        check({tag, "_evt"},   64'(EVENT_COUNT), 64'(0));
        check({tag, "_drop"},  64'(DROP_COUNT),  64'(0));
    endtask

    initial begin
        RESET      = 1'b0;
        TRIGGER_IN = 1'b0;
        read_mode  = 1'b0;
        RD_EN      = 1'b0;
        set_cfg(8'd0);
        model_reset();
        #12;
        check_reset_outputs("reset");
        @(negedge CLK);
        RESET = 1'b1;

        // 1: sustained trigger gives one event stamped 100
        do_clear();
        run_until(32'd100);
        TRIGGER_IN = 1'b1;
        repeat (5) step();
        TRIGGER_IN = 1'b0;
        check("t1_count", 64'(FIFO_COUNT), 64'(1));
        check("t1_evt",   64'(EVENT_COUNT), 64'(1));
        RD_EN = 1'b1;
        step();
        RD_EN = 1'b0;
        check("t1_valid", 64'(RD_VALID), 64'(1));
        check("t1_data",  64'(RD_DATA),  64'(100));
        step();
        check("t1_valid_one_cycle", 64'(RD_VALID), 64'(0));

        // 2: hold-off of 10 rejects the pulse at 205
        set_cfg(8'd10);
        do_clear();
        run_until(32'd200); pulse();
        run_until(32'd205); pulse();
        run_until(32'd212); pulse();
        check("t2_count", 64'(FIFO_COUNT),  64'(2));
        check("t2_evt",   64'(EVENT_COUNT), 64'(2));
        check("t2_drop",  64'(DROP_COUNT),  64'(0));
        RD_EN = 1'b1;
        step();
        check("t2_data0", 64'(RD_DATA), 64'(200));
        step();
        check("t2_data1", 64'(RD_DATA), 64'(212));
        RD_EN = 1'b0;
        step();
        check("t2_empty", 64'(FIFO_EMPTY), 64'(1));

        // 3: overflow, then drain in order (pulses at 0,2,4,...)
        set_cfg(8'd0);
        do_clear();
        for (int k = 0; k < 20; k++) pulse();
        check("t3_full",  64'(FIFO_FULL),   64'(1));
        check("t3_count", 64'(FIFO_COUNT),  64'(16));
        check("t3_evt",   64'(EVENT_COUNT), 64'(20));
        check("t3_drop",  64'(DROP_COUNT),  64'(4));
        RD_EN = 1'b1;
        for (int k = 0; k < 16; k++) begin
            step();
            check("t3_pop_valid", 64'(RD_VALID), 64'(1));
            check("t3_pop_data",  64'(RD_DATA),  64'(2 * k));
        end
        RD_EN = 1'b0;
        check("t3_empty", 64'(FIFO_EMPTY), 64'(1));
        step();
        check("t3_no_valid", 64'(RD_VALID), 64'(0));

        // 4: accept + pop on full, then on empty
        do_clear();
        for (int k = 0; k < 16; k++) pulse();
        check("t4_full", 64'(FIFO_FULL), 64'(1));
        TRIGGER_IN = 1'b1;
        RD_EN      = 1'b1;
        step();
        TRIGGER_IN = 1'b0;
        RD_EN      = 1'b0;
        check("t4_full_count", 64'(FIFO_COUNT), 64'(16));
        check("t4_full_drop",  64'(DROP_COUNT), 64'(0));
        check("t4_full_valid", 64'(RD_VALID),   64'(1));
        check("t4_full_data",  64'(RD_DATA),    64'(0));
        step();
        do_clear();
        TRIGGER_IN = 1'b1;
        RD_EN      = 1'b1;
        step();
        TRIGGER_IN = 1'b0;
        RD_EN      = 1'b0;
        check("t4_empty_count", 64'(FIFO_COUNT), 64'(1));
        check("t4_empty_valid", 64'(RD_VALID),   64'(0));
        step();
        check("t4_empty_valid_next", 64'(RD_VALID), 64'(0));

        // 5: read_mode blocks accepts but not pops
        do_clear();
        read_mode = 1'b1;
        repeat (3) pulse();
        read_mode = 1'b0;
        pulse();
        check("t5_evt",   64'(EVENT_COUNT), 64'(1));
        check("t5_count", 64'(FIFO_COUNT),  64'(1));
        read_mode  = 1'b1;
        RD_EN      = 1'b1;
        TRIGGER_IN = 1'b1;
        step();
        TRIGGER_IN = 1'b0;
        RD_EN      = 1'b0;
        check("t5_pop_valid", 64'(RD_VALID),    64'(1));
        check("t5_pop_data",  64'(RD_DATA),     64'(6));
        check("t5_pop_count", 64'(FIFO_COUNT),  64'(0));
        check("t5_pop_evt",   64'(EVENT_COUNT), 64'(1));
        read_mode = 1'b0;
        step();

        // 6: clear flushes and restarts time; async reset mid-readout
        do_clear();
        repeat (5) pulse();
        check("t6_count", 64'(FIFO_COUNT), 64'(5));
        mconfig[8] = 1'b1;
        step();
        mconfig[8] = 1'b0;
        check("t6_clr_empty", 64'(FIFO_EMPTY),  64'(1));
        check("t6_clr_count", 64'(FIFO_COUNT),  64'(0));
        check("t6_clr_evt",   64'(EVENT_COUNT), 64'(0));
        check("t6_clr_drop",  64'(DROP_COUNT),  64'(0));
        TRIGGER_IN = 1'b1;
        step();
        TRIGGER_IN = 1'b0;
        RD_EN      = 1'b1;
        step();
        RD_EN = 1'b0;
        check("t6_ts_restart_valid", 64'(RD_VALID), 64'(1));
        check("t6_ts_restart_data",  64'(RD_DATA),  64'(0));
        repeat (2) pulse();
        RD_EN = 1'b1;
        step();
        RD_EN = 1'b0;
        check("t6_pre_reset_valid", 64'(RD_VALID), 64'(1));
        #2;
        RESET = 1'b0;
        #1;
        check_reset_outputs("t6_async");
        model_reset();
        TRIGGER_IN = 1'b1;
        @(negedge CLK);
        RESET = 1'b1;
        step();
        TRIGGER_IN = 1'b0;
        check("t6_release_edge_evt",   64'(EVENT_COUNT), 64'(1));
        check("t6_release_edge_count", 64'(FIFO_COUNT),  64'(1));
        step();

        // Randomised traffic against the reference
        set_cfg(8'd0);
        do_clear();
        for (int i = 0; i < 3000; i++) begin
            TRIGGER_IN = ($urandom_range(0, 99) < 45);
            RD_EN      = ($urandom_range(0, 99) < (((i / 300) % 2 == 1) ? 60 : 10));
            read_mode  = ($urandom_range(0, 99) < 8);
            if (i % 200 == 0) begin
                mconfig[7:0]   = 8'($urandom_range(0, 5));
                mconfig[15:10] = 6'($urandom);
            end
            mconfig[9] = ($urandom_range(0, 99) < 95);
            mconfig[8] = ($urandom_range(0, 299) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
